// File: rtl/sprite_animator.sv
// sprite_animator
// Turns the spritestate motion word into a sprite-ROM index and a mirror flag.
// All state advances only on rising edges of the vertical-sync level, so the
// sprite shown never changes in the middle of a frame.
//
// Parameters:
//   TICKS_PER_FRAME  vsync edges per walk-animation step (1..15)
//   WALK_FRAMES      number of walk-cycle sprites (1..13)
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   frame_sync  in   vertical-sync level, synchronous to Clk
//   motion[3:0] in   {airborne, face_left, walk_right, walk_left}
//   sel[3:0]    out  sprite index: 0 idle, 1..WALK_FRAMES walk, WALK_FRAMES+1 jump
//   mirror      out  draw sprite horizontally flipped
//   anim_step   out  one-cycle pulse when the walk frame index advances
module sprite_animator #(
  parameter int TICKS_PER_FRAME = 6,
  parameter int WALK_FRAMES     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_sync,
  input  logic [3:0] motion,
  output logic [3:0] sel,
  output logic       mirror,
  output logic       anim_step
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_JUMP = 2'd2
  } state_e;

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_FRAME - 1);
  localparam logic [3:0] LAST_IDX  = 4'(WALK_FRAMES - 1);
  localparam logic [3:0] JUMP_SEL  = 4'(WALK_FRAMES + 1);

  state_e     state_q, state_d;
  logic       sync_q;
  logic       tick_s;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] walk_idx_q, walk_idx_d;
  logic [3:0] sel_q, sel_d;
  logic       mirror_q, mirror_d;
  logic       step_q, step_d;

  // sync_q resets high so a vsync already high at reset release gives no tick.
  assign tick_s = frame_sync & ~sync_q;

  // Vsync edge-detect register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= 1'b1;
    end else begin
      sync_q <= frame_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: jump beats walking; both walk bits set counts as idle.
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      if (motion[3]) begin
        state_d = ST_JUMP;
      end else if (motion[1] ^ motion[0]) begin
        state_d = ST_WALK;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output / counter logic; everything holds between ticks except the step pulse.
  // While walking, mirror_q equals the previous tick's motion[0], so it doubles
  // as the remembered walk direction for reversal detection.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    walk_idx_d = walk_idx_q;
    sel_d      = sel_q;
    mirror_d   = mirror_q;
    step_d     = 1'b0;
    if (tick_s) begin
      case (state_d)
        ST_WALK: begin
          mirror_d = motion[0];
          if ((state_q == ST_WALK) && (motion[0] == mirror_q)) begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_d = 4'd0;
              walk_idx_d = (walk_idx_q == LAST_IDX) ? 4'd0 : walk_idx_q + 4'd1;
              step_d     = 1'b1;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end else begin
            tick_cnt_d = 4'd0;
            walk_idx_d = 4'd0;
          end
          sel_d = 4'd1 + walk_idx_d;
        end
        ST_JUMP: begin
          mirror_d   = motion[2];
          tick_cnt_d = 4'd0;
          walk_idx_d = 4'd0;
          sel_d      = JUMP_SEL;
        end
        default: begin
          mirror_d   = motion[2];
          tick_cnt_d = 4'd0;
          walk_idx_d = 4'd0;
          sel_d      = 4'd0;
        end
      endcase
    end else begin
      step_d = 1'b0;
    end
  end

  // Counter and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q <= 4'd0;
      walk_idx_q <= 4'd0;
      sel_q      <= 4'd0;
      mirror_q   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      walk_idx_q <= walk_idx_d;
      sel_q      <= sel_d;
      mirror_q   <= mirror_d;
      step_q     <= step_d;
    end
  end

  assign sel       = sel_q;
  assign mirror    = mirror_q;
  assign anim_step = step_q;

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Consumes the 4-bit `motion` word produced by `spritestate` and turns it into a sprite-ROM index and horizontal-mirror flag for the color mapper. Animation advances only on vertical-sync rising edges, so the drawn sprite never changes mid-frame. The block sits between `spritestate` and the color mapper's `sel` input.

## Interface
- `TICKS_PER_FRAME`, default 6: vsync edges per walk-animation step; legal range 1..15.
- `WALK_FRAMES`, default 4: number of walk-cycle sprites; legal range 1..13.
- `Clk` in 1: system clock; all state is on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_sync` in 1: level vertical-sync signal, synchronous to `Clk`.
- `motion` in 4: bit0 = walk left, bit1 = walk right, bit2 = facing left (1) or right (0), bit3 = airborne/jump.
- `sel` out 4: sprite ROM index. 0 = idle, 1..`WALK_FRAMES` = walk frames, `WALK_FRAMES`+1 = jump.
- `mirror` out 1: 1 = draw sprite horizontally flipped (facing left).
- `anim_step` out 1: one-cycle pulse when the walk frame index advances.

## Operation
- Vsync edge detect:
  - `sync_d` registers `frame_sync`.
  - `tick = frame_sync & ~sync_d`.
  - `sync_d` resets to 1, so a high `frame_sync` at reset release gives no tick.
- State machine: IDLE, WALK, JUMP. State is evaluated only in cycles where `tick` = 1; otherwise all registers hold.
- Next state on `tick`:
  - `motion[3]` = 1 → JUMP. Jump has priority over walking.
  - else exactly one of `motion[1:0]` set → WALK.
  - else IDLE. Both walk bits set is treated as idle.
- Mirror on `tick`:
  - next state WALK: `mirror` = `motion[0]`.
  - otherwise: `mirror` = `motion[2]`.
- Walk counters: `tick_cnt` (4 bit) and `walk_idx` (4 bit).
  - Entering WALK from IDLE/JUMP: `tick_cnt` = 0, `walk_idx` = 0, no `anim_step`.
  - Direction reversal inside WALK (walk bit differs from previous tick): same restart as entering WALK.
  - Continuing WALK, same direction:
    - if `tick_cnt` = `TICKS_PER_FRAME`-1: `tick_cnt` = 0, `walk_idx` = (`walk_idx`+1) mod `WALK_FRAMES`, `anim_step` pulses.
    - else `tick_cnt`++.
  - Leaving WALK: counters are cleared to 0.
- `sel` mapping (registered):
  - IDLE → 0.
  - WALK → 1 + `walk_idx`.
  - JUMP → `WALK_FRAMES` + 1.
- `TICKS_PER_FRAME` = 1: `walk_idx` advances on every continuing tick.
- `WALK_FRAMES` = 1: `walk_idx` stays 0, but `anim_step` still pulses on wrap.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `sel` = 0, `mirror` = 0, `anim_step` = 0, `tick_cnt` = 0, `walk_idx` = 0, `sync_d` = 1.
- Latency:
  - `frame_sync` sampled 1 after a sampled 0 at edge N → `tick` during that cycle.
  - `sel`, `mirror` and state update at the edge that samples `tick` = 1, visible one clock later.
  - `anim_step` is high for exactly that one following cycle.
- `motion` is sampled only at tick edges. Changes between ticks have no effect, even if they revert before the next tick.
- `frame_sync` held high for many cycles yields exactly one tick. Re-arming requires at least one cycle of `frame_sync` = 0.
- Reset asserted mid-walk clears all state immediately. The first tick after release restarts from IDLE rules.
- Outputs are glitch-free registers; none is combinational from inputs.

## Test plan
All scenarios use the defaults (6, 4) unless stated.
- **Reset / idle:** `Reset` pulse with `frame_sync` = 1 held → `sel` = 0, `mirror` = 0, no tick until `frame_sync` falls and rises again.
- **Walk right:** `motion` = 4'b0010, 13 vsync pulses →
  - `sel` = 1 after the first tick.
  - `sel` = 2 after tick 7, with `anim_step` pulsing once at that point.
  - `sel` = 3 after tick 13.
  - `mirror` = 0 throughout.
- **Wrap-around:** continuous right walk for 25 ticks → `sel` sequence 1,2,3,4,1 at ticks 1, 7, 13, 19, 25.
- **Reversal and face retention:**
  - walk right to `sel` = 3, then `motion` = 4'b0001 on the next tick → `sel` = 1, `mirror` = 1.
  - then `motion` = 4'b0100 → `sel` = 0, `mirror` = 1.
  - then `motion` = 4'b0000 → `mirror` = 0.
- **Jump priority:** `motion` = 4'b1011 → `sel` = 5, `mirror` = 0. `motion` = 4'b1100 → `sel` = 5, `mirror` = 1. `motion` = 4'b0011 → `sel` = 0.
- **Sampling discipline:** toggle `motion` several times between ticks and assert `Reset` mid-walk → outputs change only at tick edges; reset returns `sel` = 0 within the same cycle.
